// File: rtl/rx_chan_packer.sv
// RX channel packer: snapshots up to NCHAN 16-bit channels on each strobe and streams them as framed 16-bit words.
// Define RX_CHAN_PACKER_OVRCNT_EN to add the saturating dropped-strobe counter output ovr_count.
module rx_chan_packer #(
    parameter int NCHAN = 8,
    parameter int CW    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  strobe,
    input  logic [CW-1:0]         nchan,
    input  logic                  bw8,
    input  logic [16*NCHAN-1:0]   din,
    output logic [15:0]           out_data,
    output logic                  out_valid,
    output logic                  out_first,
    output logic                  out_last,
    input  logic                  out_ready,
    input  logic                  clear_status,
    output logic                  overrun,
`ifdef RX_CHAN_PACKER_OVRCNT_EN
    output logic [15:0]           ovr_count,
`endif
    output logic                  busy
);
    // state | meaning
    // IDLE  | waiting for a strobe with a non-zero channel count
    // EMIT  | streaming words of the shadowed sample set
    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [CW-1:0] NMAX = CW'(NCHAN);

    state_t              state, state_nxt;
    logic [16*NCHAN-1:0] sh_din;
    logic [CW-1:0]       sh_n, sh_words, w;
    logic                sh_bw8;
    logic [CW-1:0]       n_eff, n_words;
    logic                emitting, xfer, last_word, final_xfer, start_ok, load, drop;
    logic [15:0]         ch_w, ch_lo, ch_hi, word8;
    logic                hi_valid;

    function automatic logic [7:0] rnd8(input logic [15:0] x);
        return x[15:8] + {7'b0, x[15] & (|x[7:0])};
    endfunction

    assign n_eff      = (nchan > NMAX) ? NMAX : nchan;
    assign n_words    = bw8 ? ((n_eff >> 1) + {{(CW-1){1'b0}}, n_eff[0]}) : n_eff;
    assign emitting   = (state == EMIT);
    assign xfer       = emitting && out_ready;
    assign last_word  = (w == sh_words - CW'(1));
    assign final_xfer = xfer && last_word;
    assign start_ok   = strobe && (n_eff != '0);
    // A strobe coinciding with the final transfer chains straight into the next frame.
    assign load       = start_ok && (!emitting || final_xfer);
    assign drop       = start_ok && emitting && !final_xfer;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load) state_nxt = EMIT;
            EMIT: if (final_xfer && !load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sh_din   <= '0;
            sh_n     <= '0;
            sh_words <= '0;
            sh_bw8   <= 1'b0;
            w        <= '0;
            overrun  <= 1'b0;
        end else begin
            if (load) begin
                sh_din   <= din;
                sh_n     <= n_eff;
                sh_words <= n_words;
                sh_bw8   <= bw8;
                w        <= '0;
            end else if (xfer) begin
                w <= w + CW'(1);
            end
            if (drop)              overrun <= 1'b1;
            else if (clear_status) overrun <= 1'b0;
        end
    end

`ifdef RX_CHAN_PACKER_OVRCNT_EN
    always_ff @(posedge clock) begin
        if (reset)                   ovr_count <= '0;
        else if (drop && clear_status) ovr_count <= 16'd1;
        else if (drop)               ovr_count <= (ovr_count == 16'hFFFF) ? ovr_count : ovr_count + 16'd1;
        else if (clear_status)       ovr_count <= '0;
    end
`endif

    always_comb begin
        ch_w  = '0;
        ch_lo = '0;
        ch_hi = '0;
        for (int k = 0; k < NCHAN; k++) begin
            if (k == int'(w))         ch_w  = sh_din[16*k +: 16];
            if (k == 2*int'(w))       ch_lo = sh_din[16*k +: 16];
            if (k == 2*int'(w) + 1)   ch_hi = sh_din[16*k +: 16];
        end
    end

    assign hi_valid = (2*int'(w) + 1) < int'(sh_n);
    assign word8    = {hi_valid ? rnd8(ch_hi) : 8'h00, rnd8(ch_lo)};

    always_comb begin
        out_valid = emitting;
        busy      = emitting;
        out_first = emitting && (w == '0);
        out_last  = emitting && last_word;
        out_data  = emitting ? (sh_bw8 ? word8 : ch_w) : 16'h0000;
    end
endmodule
